freespeech_sequencer: RTL

Message sequencer that drives the 4-bit `hex` input of the segment decoder. It stores a short message of 4-bit character codes and steps through them at a programmable rate, looping while enabled. An optional blank gap can be inserted between characters. It sits between the top-level I/O (write port, run and rate controls) and the combinational decoder.

---
 rtl/freespeech_sequencer_pkg.sv | 16 +
 rtl/freespeech_sequencer_if.sv | 32 +++
 rtl/fs_dwell_counter.sv | 31 +++
 rtl/freespeech_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/freespeech_sequencer_pkg.sv
// Shared types and constants for the freespeech message sequencer.
package freespeech_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_SHOW = 2'd1,
    FS_GAP  = 2'd2
  } fs_state_t;

  // Character code the segment decoder renders as all-off.
  localparam logic [3:0] FS_BLANK = 4'hF;

  localparam int FS_DEPTH = 16;
  localparam int FS_DIV_W = 16;

endpackage

// File: rtl/freespeech_sequencer_if.sv
// Write port, run/rate controls and display outputs of the sequencer.
// master: the top-level I/O side; slave: the sequencer itself.
interface freespeech_sequencer_if
  import freespeech_pkg::*;
#(
  parameter int DEPTH = FS_DEPTH,
  parameter int DIV_W = FS_DIV_W
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [3:0]       wr_data;
  logic [AW:0]      len;
  logic [DIV_W-1:0] period;
  logic             run;
  logic [3:0]       hex;
  logic [AW-1:0]    pos;
  logic             busy;
  logic             wrap;

  modport master (
    output wr_en, wr_addr, wr_data, len, period, run,
    input  hex, pos, busy, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, period, run,
    output hex, pos, busy, wrap
  );

endinterface

// File: rtl/fs_dwell_counter.sv
// Loadable down-counter timing the dwell of one character or gap.
// o_tc is high while the count sits at zero (the last dwell cycle).
module fs_dwell_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/freespeech_sequencer.sv
// Message sequencer feeding the 4-bit hex input of the segment decoder.
// Steps through len stored character codes, each held for max(period,1)
// cycles, looping while run is high.
// Define FREESPEECH_GAP_EN to insert a blank of the same length after
// every character, including the last one before a wrap.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   FS_IDLE | stopped, hex blank, waiting for run with len != 0
//   FS_SHOW | hex holds mem[pos] for the current dwell
//   FS_GAP  | blank after mem[pos] (only with FREESPEECH_GAP_EN)
module freespeech_sequencer
  import freespeech_pkg::*;
#(
  parameter int DEPTH = FS_DEPTH,
  parameter int DIV_W = FS_DIV_W
) (
  input logic                  clk,
  input logic                  rst_n,
  freespeech_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]       r_mem [DEPTH];
  fs_state_t        r_state;
  logic [3:0]       r_hex;
  logic [AW-1:0]    r_pos;
  logic             r_busy;
  logic             r_wrap;
  logic [AW:0]      r_len_l;
  logic [DIV_W-1:0] r_period_l;

  logic [DIV_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_cnt_load;
  logic [DIV_W-1:0] w_cnt_val;
  logic             w_cnt_dec;

  logic [DIV_W-1:0] w_p_new;
  logic [DIV_W-1:0] w_p_lat;
  logic [AW-1:0]    w_pos_nxt;
  logic             w_last;
  logic             w_nxt_last;
  logic             w_len_ok;
  logic             w_start_wrap;
  logic             w_lat_one;
  logic             w_cnt_one;

  // P = max(period, 1), for a fresh start and for the latched message.
  assign w_p_new      = (bus.period == '0) ? DIV_W'(1) : bus.period;
  assign w_p_lat      = (r_period_l == '0) ? DIV_W'(1) : r_period_l;
  assign w_pos_nxt    = r_pos + AW'(1);
  assign w_last       = ({1'b0, r_pos} == (r_len_l - (AW+1)'(1)));
  assign w_nxt_last   = ({1'b0, w_pos_nxt} == (r_len_l - (AW+1)'(1)));
  assign w_len_ok     = bus.run && (bus.len != '0);
  // A one-cycle, one-character message is its own last dwell cycle.
  assign w_start_wrap = (w_p_new == DIV_W'(1)) && (bus.len == (AW+1)'(1));
  assign w_lat_one    = (w_p_lat == DIV_W'(1));
  assign w_cnt_one    = (w_cnt == DIV_W'(1));

  // Buffer write port; loads in the same cycle still see the old entry.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Dwell counter control: reload on every character/gap entry, else count down.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      FS_IDLE: begin
        if (w_len_ok) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = w_p_new - DIV_W'(1);
        end
      end
      FS_SHOW: begin
        if (w_tc) begin
          if (!w_last) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = w_p_lat - DIV_W'(1);
`ifdef FREESPEECH_GAP_EN
          end else if (bus.run) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = w_p_lat - DIV_W'(1);
`else
          end else if (w_len_ok) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = w_p_new - DIV_W'(1);
`endif
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
`ifdef FREESPEECH_GAP_EN
      FS_GAP: begin
        if (w_tc) begin
          if (!w_last) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = w_p_lat - DIV_W'(1);
          end else if (w_len_ok) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = w_p_new - DIV_W'(1);
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  fs_dwell_counter #(.W(DIV_W)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // Sequencing FSM with registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FS_IDLE;
      r_hex      <= FS_BLANK;
      r_pos      <= '0;
      r_busy     <= 1'b0;
      r_wrap     <= 1'b0;
      r_len_l    <= '0;
      r_period_l <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        FS_IDLE: begin
          r_hex  <= FS_BLANK;
          r_pos  <= '0;
          r_busy <= 1'b0;
          if (w_len_ok) begin
            r_state    <= FS_SHOW;
            r_len_l    <= bus.len;
            r_period_l <= bus.period;
            r_hex      <= r_mem[0];
            r_busy     <= 1'b1;
            r_wrap     <= w_start_wrap;
          end
        end
        FS_SHOW: begin
          if (w_tc) begin
            if (!w_last) begin
`ifdef FREESPEECH_GAP_EN
              r_state <= FS_GAP;
              r_hex   <= FS_BLANK;
`else
              r_pos   <= w_pos_nxt;
              r_hex   <= r_mem[w_pos_nxt];
              r_wrap  <= w_lat_one && w_nxt_last;
`endif
`ifdef FREESPEECH_GAP_EN
            end else if (bus.run) begin
              r_state <= FS_GAP;
              r_hex   <= FS_BLANK;
`else
            end else if (w_len_ok) begin
              r_len_l    <= bus.len;
              r_period_l <= bus.period;
              r_pos      <= '0;
              r_hex      <= r_mem[0];
              r_wrap     <= w_start_wrap;
`endif
            end else begin
              r_state <= FS_IDLE;
              r_hex   <= FS_BLANK;
              r_pos   <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_wrap <= w_cnt_one && w_last;
          end
        end
`ifdef FREESPEECH_GAP_EN
        FS_GAP: begin
          if (w_tc) begin
            if (!w_last) begin
              r_state <= FS_SHOW;
              r_pos   <= w_pos_nxt;
              r_hex   <= r_mem[w_pos_nxt];
              r_wrap  <= w_lat_one && w_nxt_last;
            end else if (w_len_ok) begin
              r_state    <= FS_SHOW;
              r_len_l    <= bus.len;
              r_period_l <= bus.period;
              r_pos      <= '0;
              r_hex      <= r_mem[0];
              r_wrap     <= w_start_wrap;
            end else begin
              r_state <= FS_IDLE;
              r_hex   <= FS_BLANK;
              r_pos   <= '0;
              r_busy  <= 1'b0;
            end
          end
        end
`endif
        default: begin
          r_state <= FS_IDLE;
          r_hex   <= FS_BLANK;
          r_pos   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hex  = r_hex;
  assign bus.pos  = r_pos;
  assign bus.busy = r_busy;
  assign bus.wrap = r_wrap;

endmodule
